// File: rtl/fifo_burst_reader.sv
// Purpose : pop-side consumer for a show-ahead register FIFO; drains it in fixed
//           BURST_LEN bursts (or a short residual burst on flush) onto a registered
//           valid/ready/last stream toward the DMA TX path, one burst in flight.
// Latency : first beat valid 2 cycles after a qualifying fifoDepth is seen in IDLE;
//           back-to-back beats at full rate while txReady is held high.
// Backpressure: txReady low stalls the stream; txData/txLast hold and no pop is issued
//           until the held beat is accepted. An empty FIFO mid-burst just stalls.
// Ports:
//   clockCore, resetCore        rising-edge clock, async active-low reset
//   enable, flush               permit full bursts / 1-cycle residual drain request
//   fifoData/fifoEmpty/fifoDepth FIFO head word, empty flag, occupancy
//   fifoPop                     combinational pop strobe (head consumed this edge)
//   txData/txValid/txLast/txReady  registered output stream
//   burstDone, flushDone        1-cycle completion pulses
module fifo_burst_reader #(
  parameter int DATA_W    = 16,
  parameter int DEPTH_W   = 3,
  parameter int BURST_LEN = 4
) (
  input  logic               clockCore,
  input  logic               resetCore,
  input  logic               enable,
  input  logic               flush,
  input  logic [DATA_W-1:0]  fifoData,
  input  logic               fifoEmpty,
  input  logic [DEPTH_W-1:0] fifoDepth,
  output logic               fifoPop,
  output logic [DATA_W-1:0]  txData,
  output logic               txValid,
  output logic               txLast,
  input  logic               txReady,
  output logic               burstDone,
  output logic               flushDone
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BURST = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [DEPTH_W-1:0] BURST_LEN_W = DEPTH_W'(BURST_LEN);
  localparam logic [DEPTH_W-1:0] ONE_W       = DEPTH_W'(1);

  logic [1:0]         state;
  logic               flushPend;
  logic               flushBurst;   // current burst was started by a flush
  logic [DEPTH_W-1:0] beatCnt;
  logic [DEPTH_W-1:0] burstLen;

  logic               fullGo;
  logic               lastBeat;
  logic [DEPTH_W-1:0] residualLen;

  assign fullGo      = enable && (fifoDepth >= BURST_LEN_W);
  assign lastBeat    = (beatCnt == (burstLen - ONE_W));
  assign residualLen = (fifoDepth < BURST_LEN_W) ? fifoDepth : BURST_LEN_W;

  // Pop only when the output register is free or being emptied this edge, so a
  // stalled beat is never overwritten.
  assign fifoPop = (state == BURST) && !fifoEmpty && (!txValid || txReady);

  always_ff @(posedge clockCore or negedge resetCore) begin
    if (!resetCore) begin
      state      <= IDLE;
      flushPend  <= 1'b0;
      flushBurst <= 1'b0;
      beatCnt    <= '0;
      burstLen   <= '0;
      txData     <= '0;
      txValid    <= 1'b0;
      txLast     <= 1'b0;
      burstDone  <= 1'b0;
      flushDone  <= 1'b0;
    end else begin
      burstDone <= 1'b0;
      flushDone <= 1'b0;

      // Sticky request; a flush landing in the cycle the pending one retires is
      // absorbed by that retirement (the clear below wins).
      if (flush) begin
        flushPend <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (fullGo) begin
            // Full burst wins over a pending flush, which stays armed.
            burstLen   <= BURST_LEN_W;
            beatCnt    <= '0;
            flushBurst <= 1'b0;
            state      <= BURST;
          end else if (flushPend) begin
            flushPend <= 1'b0;
            if (fifoDepth != '0) begin
              burstLen   <= residualLen;
              beatCnt    <= '0;
              flushBurst <= 1'b1;
              state      <= BURST;
            end else begin
              flushDone <= 1'b1;
            end
          end
        end

        BURST: begin
          if (fifoPop) begin
            txData  <= fifoData;
            txValid <= 1'b1;
            txLast  <= lastBeat;
            beatCnt <= beatCnt + ONE_W;
            if (lastBeat) begin
              state <= DRAIN;
            end
          end else if (txValid && txReady) begin
            txValid <= 1'b0;
          end
        end

        DRAIN: begin
          // Last beat is held in the output register; wait for its handshake.
          if (txValid && txReady) begin
            txValid    <= 1'b0;
            txLast     <= 1'b0;
            burstDone  <= 1'b1;
            flushDone  <= flushBurst;
            flushBurst <= 1'b0;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
